// File: rtl/data_block_scheduler_if.sv
// Register-file / data-control bundle of data_block_scheduler.
// master = host side that drives requests, slave = the scheduler itself.
interface data_block_scheduler_if;
  logic        start_Regs_SCH;
  logic        abort_Regs_SCH;
  logic        writeRead_Regs_SCH;
  logic        multipleData_Regs_SCH;
  logic [3:0]  blockCount_Regs_SCH;
  logic        timeout_Enable_Regs_SCH;
  logic [15:0] timeout_Reg_Regs_SCH;
  logic        fifo_OK_FIFO_SCH;
  logic        block_Done_DATA_SCH;
  logic        block_Error_DATA_SCH;
  logic        new_DAT_SCH_DATA;
  logic        writeRead_SCH_DATA;
  logic        busy_SCH_Regs;
  logic        transfer_Done_SCH_Regs;
  logic        error_SCH_Regs;
  logic        timeout_SCH_Regs;
  logic [3:0]  blocks_Left_SCH_Regs;

  modport master (
    output start_Regs_SCH, abort_Regs_SCH, writeRead_Regs_SCH, multipleData_Regs_SCH,
           blockCount_Regs_SCH, timeout_Enable_Regs_SCH, timeout_Reg_Regs_SCH,
           fifo_OK_FIFO_SCH, block_Done_DATA_SCH, block_Error_DATA_SCH,
    input  new_DAT_SCH_DATA, writeRead_SCH_DATA, busy_SCH_Regs, transfer_Done_SCH_Regs,
           error_SCH_Regs, timeout_SCH_Regs, blocks_Left_SCH_Regs
  );

  modport slave (
    input  start_Regs_SCH, abort_Regs_SCH, writeRead_Regs_SCH, multipleData_Regs_SCH,
           blockCount_Regs_SCH, timeout_Enable_Regs_SCH, timeout_Reg_Regs_SCH,
           fifo_OK_FIFO_SCH, block_Done_DATA_SCH, block_Error_DATA_SCH,
    output new_DAT_SCH_DATA, writeRead_SCH_DATA, busy_SCH_Regs, transfer_Done_SCH_Regs,
           error_SCH_Regs, timeout_SCH_Regs, blocks_Left_SCH_Regs
  );
endinterface

// File: rtl/data_block_scheduler.sv
// Block-level transfer sequencer with per-block watchdog.
// Optional single retry per block when SCH_BLOCK_RETRY_EN is defined.
module data_block_scheduler (
  input  logic                 CLK,
  input  logic                 RESET_L,
  data_block_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIFO  = 3'd1,
    ISSUE      = 3'd2,
    WAIT_BLOCK = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        write_read_q, write_read_d;
  logic [3:0]  blocks_left_q, blocks_left_d;
  logic        to_en_q, to_en_d;
  logic [15:0] to_limit_q, to_limit_d;
  logic [15:0] wdog_q, wdog_d;
  logic        error_q, error_d;
  logic        timeout_q, timeout_d;
`ifdef SCH_BLOCK_RETRY_EN
  logic        retry_used_q, retry_used_d;
`endif

  logic timeout_hit;
  assign timeout_hit = to_en_q && (wdog_q >= to_limit_q);

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q       <= IDLE;
      write_read_q  <= 1'b0;
      blocks_left_q <= 4'd0;
      to_en_q       <= 1'b0;
      to_limit_q    <= 16'd0;
      wdog_q        <= 16'd0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef SCH_BLOCK_RETRY_EN
      retry_used_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      write_read_q  <= write_read_d;
      blocks_left_q <= blocks_left_d;
      to_en_q       <= to_en_d;
      to_limit_q    <= to_limit_d;
      wdog_q        <= wdog_d;
      error_q       <= error_d;
      timeout_q     <= timeout_d;
`ifdef SCH_BLOCK_RETRY_EN
      retry_used_q  <= retry_used_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    write_read_d  = write_read_q;
    blocks_left_d = blocks_left_q;
    to_en_d       = to_en_q;
    to_limit_d    = to_limit_q;
    wdog_d        = wdog_q;
    error_d       = error_q;
    timeout_d     = timeout_q;
`ifdef SCH_BLOCK_RETRY_EN
    retry_used_d  = retry_used_q;
`endif

    // Abort freezes every counter and flag; only the state returns home.
    if (bus.abort_Regs_SCH && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_Regs_SCH) begin
            write_read_d  = bus.writeRead_Regs_SCH;
            blocks_left_d = bus.multipleData_Regs_SCH ? bus.blockCount_Regs_SCH : 4'd1;
            to_en_d       = bus.timeout_Enable_Regs_SCH;
            to_limit_d    = bus.timeout_Reg_Regs_SCH;
            error_d       = 1'b0;
            timeout_d     = 1'b0;
`ifdef SCH_BLOCK_RETRY_EN
            retry_used_d  = 1'b0;
`endif
            if (bus.multipleData_Regs_SCH && (bus.blockCount_Regs_SCH == 4'd0)) begin
              state_d = DONE;
            end else begin
              state_d = WAIT_FIFO;
            end
          end
        end
        WAIT_FIFO: begin
          if (bus.fifo_OK_FIFO_SCH) begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          wdog_d  = 16'd0;
          state_d = WAIT_BLOCK;
        end
        WAIT_BLOCK: begin
          if (wdog_q != 16'hFFFF) begin
            wdog_d = wdog_q + 16'd1;
          end
          if (bus.block_Error_DATA_SCH) begin
`ifdef SCH_BLOCK_RETRY_EN
            if (!retry_used_q) begin
              retry_used_d = 1'b1;
              state_d      = WAIT_FIFO;
            end else begin
              error_d = 1'b1;
              state_d = ERROR;
            end
`else
            error_d = 1'b1;
            state_d = ERROR;
`endif
          end else if (bus.block_Done_DATA_SCH) begin
            blocks_left_d = blocks_left_q - 4'd1;
`ifdef SCH_BLOCK_RETRY_EN
            retry_used_d  = 1'b0;
`endif
            state_d = (blocks_left_q == 4'd1) ? DONE : WAIT_FIFO;
          end else if (timeout_hit) begin
            timeout_d = 1'b1;
            state_d   = ERROR;
          end
        end
        DONE:    state_d = IDLE;
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.new_DAT_SCH_DATA       = (state_q == ISSUE) || (state_q == WAIT_BLOCK);
  assign bus.writeRead_SCH_DATA     = write_read_q;
  assign bus.busy_SCH_Regs          = (state_q != IDLE);
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign bus.transfer_Done_SCH_Regs = (state_q == DONE) && !bus.abort_Regs_SCH;
  assign bus.error_SCH_Regs         = error_q;
  assign bus.timeout_SCH_Regs       = timeout_q;
  assign bus.blocks_Left_SCH_Regs   = blocks_left_q;

endmodule

// File: tb/tb_data_block_scheduler.sv
// Self-checking bench for data_block_scheduler: per-cycle compare against a
// transfer-level model, directed scenarios with literal expectations, random phase.
module tb_data_block_scheduler;

  logic CLK;
  logic RESET_L;
  data_block_scheduler_if bus();

  data_block_scheduler dut (
    .CLK    (CLK),
    .RESET_L(RESET_L),
    .bus    (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_WFIFO = 1, M_ISSUE = 2, M_BLOCK = 3, M_DONE = 4, M_ERR = 5;
  int m_ph, m_age, m_left, m_lim;
  bit m_wr, m_err, m_to, m_ten, m_retried;

  initial begin
    m_ph = M_IDLE; m_age = 0; m_left = 0; m_lim = 0;
    m_wr = 0; m_err = 0; m_to = 0; m_ten = 0; m_retried = 0;
    forever begin
      @(posedge CLK or negedge RESET_L);
      if (!RESET_L) begin
        m_ph = M_IDLE; m_age = 0; m_left = 0; m_lim = 0;
        m_wr = 0; m_err = 0; m_to = 0; m_ten = 0; m_retried = 0;
      end else if (m_ph != M_IDLE && bus.abort_Regs_SCH) begin
        m_ph = M_IDLE;
      end else begin
        case (m_ph)
          M_IDLE: if (bus.start_Regs_SCH) begin
            m_wr      = bus.writeRead_Regs_SCH;
            m_left    = bus.multipleData_Regs_SCH ? int'(bus.blockCount_Regs_SCH) : 1;
            m_ten     = bus.timeout_Enable_Regs_SCH;
            m_lim     = int'(bus.timeout_Reg_Regs_SCH);
            m_err     = 0;
            m_to      = 0;
            m_retried = 0;
            m_ph      = (m_left == 0) ? M_DONE : M_WFIFO;
          end
          M_WFIFO: if (bus.fifo_OK_FIFO_SCH) m_ph = M_ISSUE;
          M_ISSUE: begin
            m_age = 0;
            m_ph  = M_BLOCK;
          end
          M_BLOCK: begin
            if (bus.block_Error_DATA_SCH) begin
`ifdef SCH_BLOCK_RETRY_EN
              if (!m_retried) begin
                m_retried = 1;
                m_ph = M_WFIFO;
              end else begin
                m_err = 1;
                m_ph = M_ERR;
              end
`else
              m_err = 1;
              m_ph = M_ERR;
`endif
            end else if (bus.block_Done_DATA_SCH) begin
              m_left    = m_left - 1;
              m_retried = 0;
              m_ph      = (m_left == 0) ? M_DONE : M_WFIFO;
            end else if (m_ten && m_age >= m_lim) begin
              m_to = 1;
              m_ph = M_ERR;
            end
            m_age = m_age + 1;
          end
          default: m_ph = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- compare + monitor ----------------
  int n_win = 0, n_done = 0, n_busy = 0, n_new = 0;
  int left_at_issue[$];
  bit prev_new = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_L) begin
        chk("new_DAT", bus.new_DAT_SCH_DATA, (m_ph == M_ISSUE || m_ph == M_BLOCK));
        chk("busy", bus.busy_SCH_Regs, (m_ph != M_IDLE));
        chk("transfer_Done", bus.transfer_Done_SCH_Regs, (m_ph == M_DONE && !bus.abort_Regs_SCH));
        chk("error", bus.error_SCH_Regs, m_err);
        chk("timeout", bus.timeout_SCH_Regs, m_to);
        chk("blocks_Left", bus.blocks_Left_SCH_Regs, m_left);
        chk("writeRead", bus.writeRead_SCH_DATA, m_wr);
        if (bus.new_DAT_SCH_DATA && !prev_new) begin
          n_win++;
          left_at_issue.push_back(int'(bus.blocks_Left_SCH_Regs));
        end
        if (bus.new_DAT_SCH_DATA) n_new++;
        if (bus.transfer_Done_SCH_Regs) n_done++;
        if (bus.busy_SCH_Regs) n_busy++;
      end
      prev_new = bus.new_DAT_SCH_DATA;
    end
  end

  // ---------------- block responder ----------------
  // 0: silent, 1: done after delay, 2: error+done after delay, 3: random pulses
  int resp_mode = 0;
  int resp_delay = 5;
  int resp_cnt = 0;

  initial begin
    bus.block_Done_DATA_SCH  = 1'b0;
    bus.block_Error_DATA_SCH = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (bus.new_DAT_SCH_DATA) resp_cnt++;
      else resp_cnt = 0;
      bus.block_Done_DATA_SCH  = 1'b0;
      bus.block_Error_DATA_SCH = 1'b0;
      case (resp_mode)
        1: bus.block_Done_DATA_SCH = (resp_cnt == resp_delay + 1);
        2: begin
          bus.block_Done_DATA_SCH  = (resp_cnt == resp_delay + 1);
          bus.block_Error_DATA_SCH = (resp_cnt == resp_delay + 1);
        end
        3: begin
          bus.block_Done_DATA_SCH  = ($urandom % 6) == 0;
          bus.block_Error_DATA_SCH = ($urandom % 14) == 0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic start_xfer(input bit wr, input bit mult, input logic [3:0] cnt,
                            input bit ten, input logic [15:0] lim);
    bus.writeRead_Regs_SCH      = wr;
    bus.multipleData_Regs_SCH   = mult;
    bus.blockCount_Regs_SCH     = cnt;
    bus.timeout_Enable_Regs_SCH = ten;
    bus.timeout_Reg_Regs_SCH    = lim;
    bus.start_Regs_SCH          = 1'b1;
    cyc();
    bus.start_Regs_SCH          = 1'b0;
    // Registers change after the start cycle; the active transfer must not see it.
    bus.writeRead_Regs_SCH      = ~wr;
    bus.multipleData_Regs_SCH   = ~mult;
    bus.blockCount_Regs_SCH     = ~cnt;
    bus.timeout_Enable_Regs_SCH = ~ten;
    bus.timeout_Reg_Regs_SCH    = 16'd1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (bus.busy_SCH_Regs && n < budget) begin
      cyc();
      n++;
    end
    chk(name, bus.busy_SCH_Regs, 1'b0);
  endtask

  int b_win, b_done, b_busy, b_new, b_q;

  task automatic snap();
    b_win  = n_win;
    b_done = n_done;
    b_busy = n_busy;
    b_new  = n_new;
    b_q    = left_at_issue.size();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    RESET_L = 1'b0;
    bus.start_Regs_SCH = 0; bus.abort_Regs_SCH = 0; bus.writeRead_Regs_SCH = 0;
    bus.multipleData_Regs_SCH = 0; bus.blockCount_Regs_SCH = 0;
    bus.timeout_Enable_Regs_SCH = 0; bus.timeout_Reg_Regs_SCH = 0;
    bus.fifo_OK_FIFO_SCH = 1;
    repeat (3) cyc();
    chk("reset_busy", bus.busy_SCH_Regs, 0);
    chk("reset_new_DAT", bus.new_DAT_SCH_DATA, 0);
    chk("reset_blocks_Left", bus.blocks_Left_SCH_Regs, 0);
    chk("reset_done", bus.transfer_Done_SCH_Regs, 0);
    chk("reset_error", bus.error_SCH_Regs, 0);
    chk("reset_timeout", bus.timeout_SCH_Regs, 0);
    RESET_L = 1'b1;
    cyc();

    // Three blocks, done 5 cycles after each issue.
    resp_mode = 1; resp_delay = 5; snap();
    start_xfer(1'b1, 1'b1, 4'd3, 1'b0, 16'd0);
    wait_idle("s3_idle", 200);
    cyc();
    chk("s3_windows", n_win - b_win, 3);
    chk("s3_done_pulses", n_done - b_done, 1);
    chk("s3_busy_cycles", n_busy - b_busy, 22);
    if (left_at_issue.size() >= b_q + 3) begin
      chk("s3_left_1st", left_at_issue[b_q], 3);
      chk("s3_left_2nd", left_at_issue[b_q + 1], 2);
      chk("s3_left_3rd", left_at_issue[b_q + 2], 1);
    end else begin
      chk("s3_issue_count", left_at_issue.size() - b_q, 3);
    end
    chk("s3_left_end", bus.blocks_Left_SCH_Regs, 0);
    chk("s3_wr_latched", bus.writeRead_SCH_DATA, 1);

    // Single block ignores blockCount.
    snap();
    start_xfer(1'b0, 1'b0, 4'd15, 1'b0, 16'd0);
    chk("s1_left_start", bus.blocks_Left_SCH_Regs, 1);
    wait_idle("s1_idle", 100);
    cyc();
    chk("s1_windows", n_win - b_win, 1);
    chk("s1_done_pulses", n_done - b_done, 1);
    chk("s1_busy_cycles", n_busy - b_busy, 8);
    chk("s1_left_end", bus.blocks_Left_SCH_Regs, 0);

    // Multi with zero blocks goes straight to DONE.
    snap();
    start_xfer(1'b0, 1'b1, 4'd0, 1'b0, 16'd0);
    wait_idle("s0_idle", 20);
    cyc();
    chk("s0_windows", n_win - b_win, 0);
    chk("s0_done_pulses", n_done - b_done, 1);
    chk("s0_busy_cycles", n_busy - b_busy, 1);

    // Watchdog: limit 100, block never completes.
    resp_mode = 0; snap();
    start_xfer(1'b1, 1'b1, 4'd2, 1'b1, 16'd100);
    wait_idle("to_idle", 400);
    cyc();
    chk("to_flag", bus.timeout_SCH_Regs, 1);
    chk("to_error", bus.error_SCH_Regs, 0);
    chk("to_new_cycles", n_new - b_new, 102);
    chk("to_left_kept", bus.blocks_Left_SCH_Regs, 2);
    chk("to_done_pulses", n_done - b_done, 0);

    // Limit 0 fails on the first WAIT_BLOCK cycle.
    snap();
    start_xfer(1'b0, 1'b0, 4'd0, 1'b1, 16'd0);
    wait_idle("to0_idle", 50);
    cyc();
    chk("to0_flag", bus.timeout_SCH_Regs, 1);
    chk("to0_new_cycles", n_new - b_new, 2);

    // Error and done together: error wins.
    resp_mode = 2; resp_delay = 3; snap();
    start_xfer(1'b1, 1'b1, 4'd2, 1'b0, 16'd0);
    wait_idle("ed_idle", 200);
    cyc();
    chk("ed_error", bus.error_SCH_Regs, 1);
    chk("ed_done_pulses", n_done - b_done, 0);
    chk("ed_left_kept", bus.blocks_Left_SCH_Regs, 2);
`ifdef SCH_BLOCK_RETRY_EN
    chk("ed_windows", n_win - b_win, 2);
`else
    chk("ed_windows", n_win - b_win, 1);
`endif

    // Asynchronous reset in the middle of WAIT_BLOCK.
    resp_mode = 0;
    start_xfer(1'b1, 1'b1, 4'd2, 1'b0, 16'd0);
    repeat (4) cyc();
    chk("ar_pre_new_DAT", bus.new_DAT_SCH_DATA, 1);
    #1 RESET_L = 1'b0;
    #1;
    chk("ar_new_DAT", bus.new_DAT_SCH_DATA, 0);
    chk("ar_busy", bus.busy_SCH_Regs, 0);
    chk("ar_blocks_Left", bus.blocks_Left_SCH_Regs, 0);
    chk("ar_wr", bus.writeRead_SCH_DATA, 0);
    cyc();
    RESET_L = 1'b1;
    resp_mode = 1; resp_delay = 2; snap();
    start_xfer(1'b0, 1'b0, 4'd0, 1'b0, 16'd0);
    wait_idle("ar_resume_idle", 50);
    cyc();
    chk("ar_resume_done", n_done - b_done, 1);

    // Abort while waiting for the FIFO.
    bus.fifo_OK_FIFO_SCH = 0; snap();
    start_xfer(1'b1, 1'b1, 4'd3, 1'b1, 16'd5);
    cyc();
    bus.abort_Regs_SCH = 1;
    cyc();
    bus.abort_Regs_SCH = 0;
    chk("ab_busy", bus.busy_SCH_Regs, 0);
    chk("ab_error", bus.error_SCH_Regs, 0);
    chk("ab_timeout", bus.timeout_SCH_Regs, 0);
    chk("ab_left", bus.blocks_Left_SCH_Regs, 3);
    cyc();
    chk("ab_windows", n_win - b_win, 0);
    chk("ab_done_pulses", n_done - b_done, 0);

    // Random phase, checked each cycle by the compare process.
    resp_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      bus.start_Regs_SCH          = ($urandom % 6) == 0;
      bus.abort_Regs_SCH          = ($urandom % 50) == 0;
      bus.fifo_OK_FIFO_SCH        = ($urandom % 4) != 0;
      bus.writeRead_Regs_SCH      = 1'($urandom);
      bus.multipleData_Regs_SCH   = ($urandom % 4) != 0;
      bus.blockCount_Regs_SCH     = 4'($urandom_range(0, 4));
      bus.timeout_Enable_Regs_SCH = 1'($urandom);
      bus.timeout_Reg_Regs_SCH    = 16'($urandom_range(0, 12));
      cyc();
    end
    bus.start_Regs_SCH = 0;
    bus.abort_Regs_SCH = 1;
    resp_mode = 0;
    cyc();
    bus.abort_Regs_SCH = 0;
    wait_idle("rnd_idle", 10);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
